// File: rtl/window_ctrl_if.sv
// rtl/window_ctrl_if.sv - pixel handshake, line-buffer enable and window/status bundle for window_ctrl
interface window_ctrl_if #(
    parameter int CW = 6
);
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic          out_ready;
    logic          lb_en;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          win_valid;
    logic [CW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          frame_done;
    logic          sync_err;
    logic          busy;

    modport master (
        output in_valid, in_sof, out_ready,
        input  in_ready, lb_en, col, row, win_valid, win_row, win_col,
               frame_done, sync_err, busy
    );

    modport slave (
        input  in_valid, in_sof, out_ready,
        output in_ready, lb_en, col, row, win_valid, win_row, win_col,
               frame_done, sync_err, busy
    );
endinterface

// File: rtl/window_ctrl.sv
// rtl/window_ctrl.sv - 3x3 sliding-window sequencer: line-buffer enable, raster position, window/frame pulses
// Optional: WINDOW_CTRL_SOF_RESYNC_EN restarts the frame on an in_sof seen outside IDLE and pulses sync_err.
module window_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CW    = 6
) (
    input  logic           clk,
    input  logic           rst,
    window_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] TWO      = CW'(2);

    state_t        state_q;
    logic [CW-1:0] col_q;
    logic [CW-1:0] row_q;
    logic          win_valid_q;
    logic [CW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;
    logic          frame_done_q;

    logic xfer;
    logic sof_restart;
    logic at_eol;
    logic at_eof;

    assign xfer   = bus.in_valid & bus.out_ready;
    assign at_eol = (col_q == COL_LAST);
    assign at_eof = at_eol & (row_q == ROW_LAST);

`ifdef WINDOW_CTRL_SOF_RESYNC_EN
    logic sync_err_q;
    assign sof_restart  = bus.in_sof & (state_q != IDLE);
    assign bus.sync_err = sync_err_q;
`else
    assign sof_restart  = 1'b0;
    assign bus.sync_err = 1'b0;
`endif

    // Combinational so the line buffers write in the accept cycle; held off while in reset.
    assign bus.in_ready   = bus.out_ready;
    assign bus.lb_en      = rst & xfer & ((state_q != IDLE) | bus.in_sof);
    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
`ifdef WINDOW_CTRL_SOF_RESYNC_EN
            sync_err_q   <= 1'b0;
`endif
        end else begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef WINDOW_CTRL_SOF_RESYNC_EN
            sync_err_q   <= 1'b0;
`endif
            if (xfer) begin
                if (state_q == IDLE) begin
                    if (bus.in_sof) begin
                        col_q   <= ONE;
                        row_q   <= '0;
                        state_q <= FILL;
                    end
                end else if (sof_restart) begin
                    col_q   <= ONE;
                    row_q   <= '0;
                    state_q <= FILL;
`ifdef WINDOW_CTRL_SOF_RESYNC_EN
                    sync_err_q <= 1'b1;
`endif
                end else begin
                    // The accepted pixel is the bottom-right corner of the window centred one up/left.
                    if (state_q == RUN && col_q >= TWO) begin
                        win_valid_q <= 1'b1;
                        win_row_q   <= row_q - ONE;
                        win_col_q   <= col_q - ONE;
                    end
                    if (state_q == RUN && at_eof) begin
                        col_q        <= '0;
                        row_q        <= '0;
                        state_q      <= IDLE;
                        frame_done_q <= 1'b1;
                    end else if (at_eol) begin
                        col_q <= '0;
                        row_q <= row_q + ONE;
                        if (row_q == ONE) begin
                            state_q <= RUN;
                        end
                    end else begin
                        col_q <= col_q + ONE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_window_ctrl.sv
// tb/tb_window_ctrl.sv - directed self-checking bench for window_ctrl (4x4 and 64x64 instances)
module tb_window_ctrl;
    logic clk;
    logic rst;
    logic clr;

    int npass;
    int ntotal;

    window_ctrl_if #(.CW(6)) sif ();
    window_ctrl_if #(.CW(6)) lif ();

    window_ctrl #(.IMG_W(4),  .IMG_H(4),  .CW(6)) dut_s (.clk(clk), .rst(rst), .bus(sif));
    window_ctrl #(.IMG_W(64), .IMG_H(64), .CW(6)) dut_l (.clk(clk), .rst(rst), .bus(lif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          s_lb, s_fd, s_se, s_fd_at, s_se_at;
    logic [11:0] s_wq[$];
    int          l_lb, l_fd, l_win, l_viol, l_frz;
    logic [11:0] l_first, l_last;
    logic [5:0]  prev_col, prev_row;
    logic        prev_xfer;

    always @(negedge clk) begin
        if (clr) begin
            s_lb <= 0; s_fd <= 0; s_se <= 0; s_fd_at <= 0; s_se_at <= 0;
            s_wq.delete();
            l_lb <= 0; l_fd <= 0; l_win <= 0; l_viol <= 0; l_frz <= 0;
            l_first <= '0; l_last <= '0;
        end else begin
            if (sif.frame_done) begin s_fd <= s_fd + 1; s_fd_at <= s_lb; end
            if (sif.sync_err)   begin s_se <= s_se + 1; s_se_at <= s_lb; end
            if (sif.win_valid)  s_wq.push_back({sif.win_row, sif.win_col});
            if (sif.lb_en)      s_lb <= s_lb + 1;
            if (lif.frame_done) l_fd <= l_fd + 1;
            if (lif.lb_en)      l_lb <= l_lb + 1;
            if (lif.win_valid) begin
                if (l_win == 0) l_first <= {lif.win_row, lif.win_col};
                l_last <= {lif.win_row, lif.win_col};
                l_win  <= l_win + 1;
            end
            if (lif.lb_en && !(lif.in_valid && lif.out_ready)) l_viol <= l_viol + 1;
            if (!prev_xfer && (lif.col != prev_col || lif.row != prev_row)) l_frz <= l_frz + 1;
        end
        prev_xfer <= lif.in_valid & lif.out_ready;
        prev_col  <= lif.col;
        prev_row  <= lif.row;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic s_drive(input logic v, input logic sof, input logic rdy);
        @(posedge clk); #2;
        sif.in_valid = v; sif.in_sof = sof; sif.out_ready = rdy;
    endtask

    task automatic s_px(input int n, input logic sof_first);
        for (int i = 0; i < n; i++) s_drive(1'b1, sof_first && (i == 0), 1'b1);
    endtask

    task automatic s_idle(input int n);
        for (int i = 0; i < n; i++) s_drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clear;
        @(posedge clk); #2; clr = 1'b1;
        @(negedge clk); #1; clr = 1'b0;
    endtask

    task automatic chk_wins(input string tag, input int base);
        logic [11:0] exp_w[4];
        exp_w[0] = {6'd1, 6'd1}; exp_w[1] = {6'd1, 6'd2};
        exp_w[2] = {6'd2, 6'd1}; exp_w[3] = {6'd2, 6'd2};
        for (int i = 0; i < 4; i++) chk(tag, 32'(s_wq[base + i]), 32'(exp_w[i]));
    endtask

    function automatic logic [29:0] outs_s();
        return {sif.in_ready, sif.lb_en, sif.busy, sif.win_valid, sif.frame_done, sif.sync_err,
                sif.col, sif.row, sif.win_row, sif.win_col};
    endfunction

    function automatic logic [29:0] outs_l();
        return {lif.in_ready, lif.lb_en, lif.busy, lif.win_valid, lif.frame_done, lif.sync_err,
                lif.col, lif.row, lif.win_row, lif.win_col};
    endfunction

`ifdef WINDOW_CTRL_SOF_RESYNC_EN
    localparam int RS_SE = 1, RS_LB = 25, RS_FD_AT = 25;
`else
    localparam int RS_SE = 0, RS_LB = 16, RS_FD_AT = 16;
`endif

    initial begin
        npass = 0; ntotal = 0;
        rst = 1'b0; clr = 1'b1;
        sif.in_valid = 1'b0; sif.in_sof = 1'b0; sif.out_ready = 1'b0;
        lif.in_valid = 1'b0; lif.in_sof = 1'b0; lif.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs_small", 32'(outs_s()), 32'd0);
        chk("reset_outs_large", 32'(outs_l()), 32'd0);
        @(posedge clk); #2; rst = 1'b1; clr = 1'b0;

        for (int i = 0; i < 3; i++) begin
            s_drive(1'b1, 1'b0, 1'b1);
            @(negedge clk);
            chk("idle_in_ready", 32'(sif.in_ready), 32'd1);
            chk("idle_lb_en", 32'(sif.lb_en), 32'd0);
        end
        s_idle(1);
        @(negedge clk);
        chk("idle_pos", 32'({sif.busy, sif.col, sif.row}), 32'd0);
        chk("idle_pulses", 32'(s_lb + s_fd + s_se + s_wq.size()), 32'd0);

        do_clear();
        s_px(16, 1'b1);
        s_idle(1);
        @(negedge clk);
        chk("f1_frame_done_pulse", 32'(sif.frame_done), 32'd1);
        chk("f1_busy_after", 32'(sif.busy), 32'd0);
        s_idle(1);
        @(negedge clk);
        chk("f1_frame_done_single", 32'(sif.frame_done), 32'd0);
        chk("f1_lb_count", 32'(s_lb), 32'd16);
        chk("f1_win_count", 32'(s_wq.size()), 32'd4);
        chk("f1_fd_count", 32'(s_fd), 32'd1);
        chk_wins("f1_win_centre", 0);
        chk("f1_pos", 32'({sif.col, sif.row}), 32'd0);

        do_clear();
        s_px(16, 1'b1);
        s_px(16, 1'b1);
        s_idle(2);
        @(negedge clk);
        chk("b2b_lb_count", 32'(s_lb), 32'd32);
        chk("b2b_win_count", 32'(s_wq.size()), 32'd8);
        chk("b2b_fd_count", 32'(s_fd), 32'd2);
        chk_wins("b2b_win_centre_f2", 4);

        do_clear();
        s_px(9, 1'b1);
        s_drive(1'b1, 1'b1, 1'b1);
        s_px(15, 1'b0);
        s_idle(2);
        @(negedge clk);
        chk("rs_sync_err_count", 32'(s_se), 32'(RS_SE));
        chk("rs_lb_count", 32'(s_lb), 32'(RS_LB));
        chk("rs_fd_count", 32'(s_fd), 32'd1);
        chk("rs_fd_at", 32'(s_fd_at), 32'(RS_FD_AT));
        chk("rs_win_count", 32'(s_wq.size()), 32'd4);
`ifdef WINDOW_CTRL_SOF_RESYNC_EN
        chk("rs_sync_err_at", 32'(s_se_at), 32'd10);
`endif

        do_clear();
        s_px(10, 1'b1);
        @(posedge clk); #2;
        rst = 1'b0;
        sif.in_valid = 1'b0; sif.in_sof = 1'b0; sif.out_ready = 1'b0;
        @(negedge clk);
        chk("mid_reset_outs", 32'(outs_s()), 32'd0);
        @(posedge clk); #2; rst = 1'b1;
        s_idle(1);
        @(negedge clk);
        chk("abort_no_fd", 32'(s_fd), 32'd0);
        do_clear();
        s_px(16, 1'b1);
        s_idle(2);
        @(negedge clk);
        chk("post_rst_win_count", 32'(s_wq.size()), 32'd4);
        chk("post_rst_fd_count", 32'(s_fd), 32'd1);
        chk("post_rst_fd_at", 32'(s_fd_at), 32'd16);

        do_clear();
        for (int i = 0; i < 8192; i++) begin
            @(posedge clk); #2;
            lif.in_valid  = 1'b1;
            lif.in_sof    = (i == 0);
            lif.out_ready = ((i % 2) == 0);
        end
        @(posedge clk); #2;
        lif.in_valid = 1'b0; lif.in_sof = 1'b0; lif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("big_win_count", 32'(l_win), 32'd3844);
        chk("big_lb_count", 32'(l_lb), 32'd4096);
        chk("big_fd_count", 32'(l_fd), 32'd1);
        chk("big_lb_without_xfer", 32'(l_viol), 32'd0);
        chk("big_counter_moved_idle", 32'(l_frz), 32'd0);
        chk("big_first_centre", 32'(l_first), 32'({6'd1, 6'd1}));
        chk("big_last_centre", 32'(l_last), 32'({6'd62, 6'd62}));
        chk("big_busy_after", 32'(lif.busy), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/window_ctrl.md
# window_ctrl

Sequencer for the 3x3 sliding-window front end: it accepts a raster pixel stream with start-of-frame marking, drives the shared enable of the two cascaded 64-deep line buffers, and tracks column and row position. It marks which accepted pixels complete a valid 3x3 window and reports frame completion. It sits between the pixel source and the line-buffer/window-register datapath and gates all datapath advancement; it carries no pixel data itself.

## Interface
- IMG_W, 64, pixels per line; must equal line-buffer depth (64) for tap alignment
- IMG_H, 64, lines per frame; legal range 3..64
- CW, 6, column/row counter width; 2^CW >= max(IMG_W, IMG_H)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  source presents a pixel
- in_sof  in  1  qualifies in_valid; pixel is (0,0) of a frame
- in_ready  out  1  controller accepts the pixel this cycle
- out_ready  in  1  window consumer can take a result
- lb_en  out  1  shared enable for both line buffers and the window shift registers
- col  out  CW  column of the next pixel to be accepted
- row  out  CW  row of the next pixel to be accepted
- win_valid  out  1  one-cycle pulse; window centred at (win_row, win_col) is complete
- win_row, win_col  out  CW each  centre coordinates of the window flagged by win_valid
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted
- sync_err  out  1  one-cycle pulse on an early in_sof; tied 0 without the macro
- busy  out  1  high in FILL or RUN

## Operation
- Transfer: xfer = in_valid & in_ready. in_ready = out_ready in every state.
- States: IDLE, FILL, RUN. Reset value is IDLE, and all outputs and counters reset to 0.
- IDLE:
  - xfer without in_sof: the pixel is discarded and lb_en stays 0.
  - xfer with in_sof: lb_en=1 and the pixel is (0,0). Set col=1, row=0, then go to FILL.
- FILL (row < 2), on each xfer:
  - lb_en=1 and col increments.
  - At col == IMG_W-1, col wraps to 0 and row increments.
  - Entering row 2 moves to RUN.
- RUN, on each xfer:
  - lb_en=1 and the counters advance as in FILL.
  - A pixel at (r,c) with c >= 2 schedules win_valid with win_row=r-1, win_col=c-1.
  - When the accepted pixel is (IMG_H-1, IMG_W-1): counters clear to 0, go to IDLE, and schedule frame_done.
- lb_en = xfer & (state != IDLE | in_sof). It is combinational so that the line buffer writes in the same cycle as the accept.
- Windows per frame: (IMG_W-2)*(IMG_H-2). No border padding; edge centres never appear.
- Counter arithmetic is unsigned CW-bit. Wrap is by compare to IMG_W-1 / IMG_H-1, never by natural overflow.

## Timing
- lb_en, in_ready: same cycle as the xfer (combinational).
- col, row, state: update on the clk edge that ends the xfer cycle.
- win_valid, win_row, win_col, frame_done: registered, asserted the cycle after the qualifying xfer, and high for exactly one cycle.
- No xfer (in_valid=0 or out_ready=0): counters and state hold, lb_en=0, no pulses.
- Back-to-back frames: an in_sof pixel offered in the cycle after frame_done is accepted and starts a new frame (IDLE → FILL).
- Reset asserted mid-frame: immediately IDLE, all outputs 0, no frame_done. Line-buffer contents are stale, but FILL re-primes them before any window.

## Configuration
- WINDOW_CTRL_SOF_RESYNC_EN defined:
  - An xfer with in_sof in FILL or RUN treats the pixel as (0,0): col=1, row=0, state FILL.
  - sync_err pulses the next cycle, and no frame_done is produced for the truncated frame.
- Not defined:
  - in_sof is ignored outside IDLE, and the pixel counts as an ordinary pixel.
  - sync_err is constant 0.

## Test plan
- IMG_W=4, IMG_H=4, continuous in_valid/out_ready, sof on the first pixel → 16 lb_en cycles, 4 win_valid pulses at centres (1,1),(1,2),(2,1),(2,2), one frame_done the cycle after pixel 16, then state IDLE.
- Pixels without sof while IDLE → in_ready=1, lb_en=0, col=row=0, no pulses.
- Default IMG_W=64, IMG_H=64, out_ready toggling every other cycle → exactly 62*62=3844 win_valid pulses, lb_en only on xfer cycles, counters frozen while out_ready=0.
- rst low during row 2 of a frame, then a new sof frame → all outputs 0 during reset, the full window count for the second frame, and no frame_done for the aborted one.
- With WINDOW_CTRL_SOF_RESYNC_EN, sof at pixel (2,1) of a 4x4 frame → sync_err pulse, restart at (0,0), and the completed restarted frame yields 4 windows and one frame_done. Without the macro, the same stimulus yields no sync_err and frame_done after pixel 16.
- Two back-to-back 4x4 frames with no gap → 8 win_valid pulses and 2 frame_done pulses, with no pixel dropped at the boundary.
